muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the pipelined CPU's EX stage. It owns the HI/LO architectural registers.
- Executes MULTU/DIVU, plus MULT/DIV when signed support is compiled in, at one bit per cycle. Also executes MTHI/MTLO.
- Raises a stall request toward the hazard logic while a result is pending and an MFHI/MFLO sits in ID.
- Generalises the single-cycle ALU path to a configurable width with a start/busy handshake and flush abort.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  issue request, sampled at rising edge
op  input  3  000 MULTU, 001 DIVU, 010 MULT, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved
src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
src_b  input  WIDTH  multiplier / divisor
flush  input  1  abort in-flight operation (EX flush)
mf_req  input  1  MFHI/MFLO present in ID stage
busy  output  1  iteration in progress
stall_req  output  1  combinational: mf_req & busy
done  output  1  one-cycle pulse when HI/LO updated
div_by_zero  output  1  one-cycle pulse with done for a zero divisor
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; the polarity and synchronicity are fixed.
- Reset (rst_n=0 at an edge), including mid-operation:
  - state IDLE; hi=0, lo=0; counter=0.
  - busy=0, done=0, div_by_zero=0; working registers cleared.
- FSM states are IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start is accepted only when busy=0. A start while busy is ignored and is not queued.
  - start with a reserved op is ignored.
- MTHI/MTLO:
  - hi (or lo) takes src_a at the accepting edge; busy stays 0.
  - done pulses in the following cycle.
- MUL:
  - Shift-add over a 2*WIDTH working product, one multiplier bit per cycle, WIDTH cycles.
  - Then go to FIX (sign correction, one cycle), then DONE.
- DIV:
  - Restoring division, one quotient bit per cycle, WIDTH cycles, then FIX, then DONE.
  - lo=quotient, hi=remainder.
- Divide by zero (src_b==0 on a divide op):
  - No iteration; go directly to DONE.
  - Result: lo = all ones, hi = src_a.
  - div_by_zero pulses together with done.
- Latency:
  - MUL/DIV: start edge to done-high cycle = WIDTH+2 cycles.
  - busy is high from the cycle after the accepting edge until the cycle done is high; it is low in the done cycle.
- Commit:
  - hi/lo are written only at the edge entering DONE.
  - Working registers are separate, so hi/lo hold their previous values throughout the operation.
- DONE lasts one cycle and returns to IDLE. A new start is accepted in the DONE cycle.
- flush:
  - In any state, flush=1 at an edge returns the FSM to IDLE.
  - hi/lo are unchanged; no done pulse.
  - If flush and start are both high in the same cycle, flush wins and start is dropped.
- stall_req has no register stage; it deasserts in the done cycle so the MF instruction reads the committed hi/lo.
- Arithmetic:
  - Full 2*WIDTH product; no overflow indication.
  - The counter counts from 0 to WIDTH-1 with no wrap beyond that.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined:
  - MULT/DIV operate on operand magnitudes; FIX negates the result as required.
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1: lo = most-negative, hi = 0, no flag.
- Undefined:
  - ops 010/011 execute as MULTU/DIVU.
  - The FIX state is still traversed, so latency is identical in both builds.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF b=0x00000002 -> done at cycle 34 after the start edge; hi=0x00000001, lo=0xFFFFFFFE; busy high for cycles 1..33.
- DIVU a=100 b=7 -> lo=14, hi=2. Second start during busy (a=1,b=1) is ignored; hi/lo unchanged until done.
- DIVU a=0x1234 b=0 -> next cycle: done=1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x00001234; busy never asserted.
- MTLO 0xAAAA0000 then MULTU 3×5 with flush at cycle 10 -> busy drops, no done pulse, lo remains 0xAAAA0000, hi unchanged.
- mf_req held during MULTU 6×7 -> stall_req=1 exactly while busy=1, low in the done cycle; lo=42 when it drops. rst_n=0 at cycle 5 of a repeat run -> hi=lo=0, busy=0 next cycle.
- MULDIV_SIGNED_EN: MULT -3×4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle, with start/busy handshake and flush abort.
// Signed MULT/DIV are compiled in with MULDIV_SIGNED_EN; otherwise they execute as MULTU/DIVU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 div_q, div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic                 accept, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

`ifdef MULDIV_SIGNED_EN
    assign signed_op = op[1];
`else
    assign signed_op = 1'b0;
`endif

    assign a_neg    = signed_op & src_a[WIDTH-1];
    assign b_neg    = signed_op & src_b[WIDTH-1];
    assign a_mag    = cond_neg_w(src_a, a_neg);
    assign b_mag    = cond_neg_w(src_b, b_neg);
    assign accept   = start & ~busy_q & ~flush & ~(op[2] & op[1]);

    // Working register holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? b_q : '0)};
    assign rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, b_q};
    assign prod_fix = cond_neg_2w(prod_q, neg_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = 1'b0;
        case (state_q)
            S_MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                else                            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                else                  prod_d = {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                else                            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_FIX: begin
                state_d = S_DONE;
                if (div_q) begin
                    lo_d = cond_neg_w(prod_q[WIDTH-1:0], neg_q);
                    hi_d = cond_neg_w(prod_q[2*WIDTH-1:WIDTH], rneg_q);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d = '0;
                    if (op[2]) begin
                        if (op[0]) lo_d = src_a;
                        else       hi_d = src_a;
                        state_d = S_DONE;
                    end else if (op[0] && src_b == '0) begin
                        lo_d    = '1;
                        hi_d    = src_a;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        div_d   = op[0];
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = op[0] & a_neg;
                        prod_d  = {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
                        b_d     = op[0] ? b_mag : a_mag;
                        state_d = op[0] ? S_DIV : S_MUL;
                    end
                end
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = 1'b0;
        end
        busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign stall_req   = mf_req & busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, flush, mf_req;
    logic [2:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          busy, stall_req, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  exp_hi = '0;
    logic [W-1:0]  exp_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .mf_req(mf_req), .busy(busy), .stall_req(stall_req), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} computed with plain wide arithmetic.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic    sgn;
        longint  sa, sb, q, r;
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        if (o[0] && y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        sa = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sb = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        if (!o[0]) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
        int   n, exp_n;
        bit   iter, busy_ok, stall_ok, hold_ok;
        logic [64:0] m;
        iter  = !o[2] && !(o[0] && y == 0);
        exp_n = iter ? W + 2 : 1;
        @(negedge clk);
        start = 1'b1; op = o; src_a = x; src_b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1; busy_ok = 1; stall_ok = 1; hold_ok = 1;
        while (!done && n < 60) begin
            if (busy !== (iter && n <= W + 1)) busy_ok = 0;
            if (stall_req !== (mf_req & busy)) stall_ok = 0;
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 0;
            start = (poke != 0 && n == poke);
            if (start) begin op = 3'b001; src_a = 1; src_b = 1; end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(exp_n));
        chk("busy_window", 64'(busy_ok), 64'd1);
        chk("stall_window", 64'(stall_ok), 64'd1);
        chk("hold_hilo", 64'(hold_ok), 64'd1);
        if (o == 3'b100) m = {1'b0, x, exp_lo};
        else if (o == 3'b101) m = {1'b0, exp_hi, x};
        else m = model(o, x, y);
        exp_hi = m[63:32];
        exp_lo = m[31:0];
        chk("done", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("stall_in_done", 64'(stall_req), 64'd0);
        chk("dbz", 64'(div_by_zero), 64'(m[64]));
        chk("hi", 64'(hi), 64'(exp_hi));
        chk("lo", 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic seen_done;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; mf_req = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        do_op(3'b000, 32'hFFFF_FFFF, 32'h2, 0);
        chk("multu_hi_const", 64'(hi), 64'h1);
        chk("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);

        do_op(3'b001, 32'd100, 32'd7, 5);
        chk("divu_lo_const", 64'(lo), 64'd14);
        chk("divu_hi_const", 64'(hi), 64'd2);

        do_op(3'b001, 32'h1234, 32'h0, 0);
        chk("dbz_lo_const", 64'(lo), 64'hFFFF_FFFF);
        chk("dbz_hi_const", 64'(hi), 64'h1234);

        // Reserved op must be ignored.
        @(negedge clk); start = 1'b1; op = 3'b110; src_a = 32'h5555; src_b = 32'h3;
        @(negedge clk); start = 1'b0;
        chk("resv_done", 64'(done), 64'd0);
        chk("resv_busy", 64'(busy), 64'd0);
        chk("resv_lo", 64'(lo), 64'(exp_lo));

        do_op(3'b101, 32'hAAAA_0000, 32'h0, 0);
        do_op(3'b100, 32'h0BAD_F00D, 32'h0, 0);

        // Flush mid-multiply at cycle 10.
        @(negedge clk); start = 1'b1; op = 3'b000; src_a = 3; src_b = 5;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        chk("flush_lo", 64'(lo), 64'hAAAA_0000);
        chk("flush_hi", 64'(hi), 64'h0BAD_F00D);

        // Flush and start together: start dropped.
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'b000; src_a = 6; src_b = 7;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("flush_start_done", 64'(done), 64'd0);

        mf_req = 1'b1;
        do_op(3'b000, 32'd6, 32'd7, 0);
        chk("mf_lo_42", 64'(lo), 64'd42);
        mf_req = 1'b0;

        // Reset in the middle of a repeat run.
        @(negedge clk); start = 1'b1; op = 3'b000; src_a = 6; src_b = 7;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;

        do_op(3'b010, 32'hFFFF_FFFD, 32'd4, 0);
`ifdef MULDIV_SIGNED_EN
        chk("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo_const", 64'(lo), 64'hFFFF_FFF4);
`else
        chk("mult_hi_const", 64'(hi), 64'h3);
        chk("mult_lo_const", 64'(lo), 64'hFFFF_FFF4);
`endif
        do_op(3'b011, 32'hFFFF_FFF9, 32'd2, 0);
`ifdef MULDIV_SIGNED_EN
        chk("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
`endif
        do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
`ifdef MULDIV_SIGNED_EN
        chk("divmin_lo_const", 64'(lo), 64'h8000_0000);
        chk("divmin_hi_const", 64'(hi), 64'h0);
`endif

        for (int i = 0; i < 24; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1, 2:    rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            do_op(ro, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
